spad_rd_seq: RTL and testbench
==============================

Name: spad_rd_seq

Overview:
- Burst read sequencer for a single scratchpad.
- Accepts a strided read command (base, length, stride) and issues one scratchpad read per cycle.
- Captures the 1-cycle-latency read data into a small credit-protected FIFO and presents it as a valid/ready stream with a last flag.
- Sits between the tile scheduler and the PE-array operand feed. The scratchpad write port is untouched.

Parameters:
- ADDR_WIDTH, 8, scratchpad address width; addresses wrap modulo 2**ADDR_WIDTH.
- DATA_WIDTH, 64, scratchpad word width.
- LEN_WIDTH, 9, burst length field width (0..2**LEN_WIDTH-1 words).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  command accepted when valid&ready.
- i_cmd_base  in  ADDR_WIDTH  first read address.
- i_cmd_len  in  LEN_WIDTH  number of words.
- i_cmd_stride  in  ADDR_WIDTH  address increment per word.
- o_spad_read_en  out  1  scratchpad read enable.
- o_spad_read_addr  out  ADDR_WIDTH  scratchpad read address.
- i_spad_data  in  DATA_WIDTH  scratchpad read data (valid 1 cycle after read_en).
- i_spad_data_valid  in  1  scratchpad read-data valid.
- o_data  out  DATA_WIDTH  stream data.
- o_data_valid  out  1  stream valid.
- o_data_last  out  1  final word of burst, qualified by o_data_valid.
- i_data_ready  in  1  downstream ready.
- o_busy  out  1  high when not IDLE.
- o_done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (sync, i_rst=1 at rising edge):
  - FSM goes to IDLE; FIFO is flushed; the in-flight flag is cleared.
  - All outputs are 0, except o_cmd_ready, which is 1 from the first cycle after reset.
  - Reset mid-burst aborts the burst: no o_done, remaining words are dropped.
- FSM states and transitions:
  - IDLE: o_cmd_ready=1.
    - Accept with len=0: no reads; o_done pulses the next cycle; stay IDLE.
    - Accept with len>0: latch base, stride, len; go to ISSUE.
  - ISSUE: o_cmd_ready=0.
    - Each cycle with credit available: assert o_spad_read_en with o_spad_read_addr=cur.
    - After each issue: cur <= (cur+stride) mod 2**ADDR_WIDTH; remaining--.
    - The read issued with remaining==1 carries the last tag; FSM then goes to DRAIN.
  - DRAIN: wait until there is no in-flight read, the FIFO is empty, and the last beat has handshaked.
    - In that handshake cycle: o_done=1 for one cycle; FSM returns to IDLE.
    - A new command is accepted starting the cycle after.
- Credit:
  - count = FIFO occupancy + in-flight (0/1).
  - Issue only when count < FIFO_DEPTH.
  - The FIFO never overflows (bench asserts this).
- Capture:
  - An in-flight register records read_en and the last tag.
  - In the next cycle, i_spad_data is pushed with its tag only if i_spad_data_valid=1 and in-flight=1.
  - Stray valids, e.g. the cycle after reset, are ignored.
- Latency: command accepted at cycle T → read_en at T+1 → data at T+2 → pushed → o_data_valid at T+3.
- Throughput: with i_data_ready held 1, one word per cycle (len words in len cycles after the first).
- Backpressure:
  - o_data, o_data_valid and o_data_last are held stable while valid&!ready.
  - Issue stalls when credits are exhausted and resumes the cycle after a pop frees one.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Stride 0 repeatedly reads base. Stride wrap past 2**ADDR_WIDTH-1 wraps to low addresses.
- o_busy = (state != IDLE).

Test Plan:
- Basic burst: base=0x10, len=4, stride=1, ready=1 → read addrs 0x10..0x13 on consecutive cycles, first o_data_valid 3 cycles after accept, 4 beats equal to the preloaded words, last on beat 4, o_done on the beat-4 handshake cycle.
- Wrap/stride: base=0xFE, len=3, stride=3 → addrs 0xFE, 0x01, 0x04; data matches.
- Backpressure: len=8, ready=0 for 10 cycles then 1 → exactly 4 reads issued before the stall, data held stable, all 8 beats in order, no FIFO overflow.
- len=0 command → no read_en, o_done pulses the cycle after accept, o_cmd_ready stays 1.
- Reset mid-burst: len=16, assert i_rst after 5 beats → next cycle all outputs 0, no o_done; a stray i_spad_data_valid is ignored; a new len=2 burst completes correctly.
- Back-to-back commands: command 2 offered during burst 1 → stalled (ready=0) until the cycle after burst-1 o_done, then accepted; streams do not interleave.

Source files
------------

// File: rtl/spad_rd_seq.sv
// rtl/spad_rd_seq.sv - strided burst read sequencer with credit-protected output FIFO
module spad_rd_seq #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = 9,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic [ADDR_WIDTH-1:0] i_cmd_base,
   input  logic [LEN_WIDTH-1:0]  i_cmd_len,
   input  logic [ADDR_WIDTH-1:0] i_cmd_stride,
   output logic                  o_spad_read_en,
   output logic [ADDR_WIDTH-1:0] o_spad_read_addr,
   input  logic [DATA_WIDTH-1:0] i_spad_data,
   input  logic                  i_spad_data_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_data_valid,
   output logic                  o_data_last,
   input  logic                  i_data_ready,
   output logic                  o_busy,
   output logic                  o_done
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] cur;
   logic [ADDR_WIDTH-1:0] stride;
   logic [LEN_WIDTH-1:0]  remaining;
   logic                  inflight;
   logic                  inflight_last;
   logic                  zero_done;
   logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         occ;
   logic [DATA_WIDTH:0]   head;
   logic                  accept;
   logic                  issue;
   logic                  last_issue;
   logic                  push;
   logic                  pop;
   logic                  fifo_valid;
   logic                  burst_done;

   // An outstanding read already owns a FIFO slot, so it counts against credit.
   assign issue      = (state == S_ISSUE) && ((occ + CW'(inflight)) < DEPTH_C);
   assign last_issue = issue && (remaining == LEN_WIDTH'(1));
   assign accept     = o_cmd_ready && i_cmd_valid;
   assign push       = inflight && i_spad_data_valid;
   assign fifo_valid = (occ != '0);
   assign pop        = fifo_valid && i_data_ready;
   assign head       = fifo_mem[rd_ptr];
   assign burst_done = (state == S_DRAIN) && pop && head[DATA_WIDTH];

   assign o_cmd_ready      = (state == S_IDLE);
   assign o_busy           = (state != S_IDLE);
   assign o_done           = burst_done || zero_done;
   assign o_spad_read_en   = issue;
   assign o_spad_read_addr = issue ? cur : '0;
   assign o_data_valid     = fifo_valid;
   assign o_data           = fifo_valid ? head[DATA_WIDTH-1:0] : '0;
   assign o_data_last      = fifo_valid && head[DATA_WIDTH];

   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {inflight_last, i_spad_data};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= S_IDLE;
         cur           <= '0;
         stride        <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         zero_done     <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         occ           <= '0;
      end else begin
         inflight      <= issue;
         inflight_last <= last_issue;
         zero_done     <= 1'b0;
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         occ <= occ + CW'(push) - CW'(pop);

         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (i_cmd_len == '0) begin
                     zero_done <= 1'b1;
                  end else begin
                     cur       <= i_cmd_base;
                     stride    <= i_cmd_stride;
                     remaining <= i_cmd_len;
                     state     <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (issue) begin
                  cur       <= cur + stride;
                  remaining <= remaining - LEN_WIDTH'(1);
                  if (last_issue) begin
                     state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (burst_done) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spad_rd_seq.sv
// tb/tb_spad_rd_seq.sv - self-checking bench for spad_rd_seq
module tb_spad_rd_seq;
   typedef struct {
      logic [7:0] base;
      logic [8:0] len;
      logic [7:0] stride;
      int         stall;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_base = '0;
   logic [8:0]  cmd_len = '0;
   logic [7:0]  cmd_stride = '0;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [63:0] spad_data = '0;
   logic        spad_valid = 1'b0;
   logic [63:0] dout;
   logic        dvalid;
   logic        dlast;
   logic        rdy = 1'b1;
   logic        busy;
   logic        done;
   logic        stray = 1'b0;

   logic [63:0] smem [256];
   logic [7:0]  addr_q [$];
   logic [64:0] beat_q [$];
   logic [64:0] mon_beat;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   rd_count = 0;
   int   beats = 0;
   int   done_count = 0;
   int   done_cyc = 0;
   int   first_valid = -1;
   int   max_occ = 0;
   logic done_last = 1'b0;
   bit   mon_en = 1'b0;
   logic prev_v = 1'b0;
   logic prev_r = 1'b0;
   logic prev_l = 1'b0;
   logic [63:0] prev_d = '0;

   vec_t vecs [5];

   spad_rd_seq #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(64),
      .LEN_WIDTH (9),
      .FIFO_DEPTH(4)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_cmd_valid      (cmd_valid),
      .o_cmd_ready      (cmd_ready),
      .i_cmd_base       (cmd_base),
      .i_cmd_len        (cmd_len),
      .i_cmd_stride     (cmd_stride),
      .o_spad_read_en   (rd_en),
      .o_spad_read_addr (rd_addr),
      .i_spad_data      (spad_data),
      .i_spad_data_valid(spad_valid),
      .o_data           (dout),
      .o_data_valid     (dvalid),
      .o_data_last      (dlast),
      .i_data_ready     (rdy),
      .o_busy           (busy),
      .o_done           (done)
   );

   always #5 clk = ~clk;

   // Scratchpad model: one-cycle read latency, plus an injectable stray valid.
   always @(posedge clk) begin
      cyc        <= cyc + 1;
      spad_valid <= rd_en | stray;
      spad_data  <= smem[rd_addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: actual=event expected=none (cycle %0d)", name, cyc);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (rd_en) begin
            rd_count++;
            if (addr_q.size() == 0) fail_now("unexpected_read");
            else chk("read_addr", 64'(rd_addr), 64'(addr_q.pop_front()));
         end
         if (dvalid && first_valid < 0) first_valid = cyc;
         if (dvalid && rdy) begin
            beats++;
            if (beat_q.size() == 0) fail_now("unexpected_beat");
            else begin
               mon_beat = beat_q.pop_front();
               chk("beat_data", dout, mon_beat[63:0]);
               chk("beat_last", 64'(dlast), 64'(mon_beat[64]));
            end
         end
         if (prev_v && !prev_r) begin
            chk("hold_valid", 64'(dvalid), 64'(prev_v));
            chk("hold_data", dout, prev_d);
            chk("hold_last", 64'(dlast), 64'(prev_l));
         end
         if (done) begin
            done_count++;
            done_cyc  = cyc;
            done_last = dvalid & rdy & dlast;
         end
         if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
         if (int'(dut.occ) > 4) fail_now("fifo_overflow");
      end
      prev_v = dvalid;
      prev_r = rdy;
      prev_d = dout;
      prev_l = dlast;
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_cmd(input logic [7:0] base, input logic [8:0] len,
                           input logic [7:0] stride, output int acc);
      int guard = 0;
      logic [7:0] a;
      step(1);
      cmd_valid  = 1'b1;
      cmd_base   = base;
      cmd_len    = len;
      cmd_stride = stride;
      while (!cmd_ready && guard < 300) begin
         step(1);
         guard++;
      end
      acc = cyc;
      if (!cmd_ready) fail_now("cmd_accept_timeout");
      else begin
         for (int k = 0; k < int'(len); k++) begin
            a = base + 8'(k) * stride;
            addr_q.push_back(a);
            beat_q.push_back({(k == int'(len) - 1), smem[a]});
         end
      end
      step(1);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int g = 0;
      while (done_count < target && g < budget) begin
         step(1);
         g++;
      end
      if (done_count < target) fail_now("done_timeout");
   endtask

   task automatic clear_counts();
      rd_count    = 0;
      beats       = 0;
      done_count  = 0;
      first_valid = -1;
      done_last   = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int acc;
      clear_counts();
      rdy = (v.stall == 0);
      send_cmd(v.base, v.len, v.stride, acc);
      if (v.stall > 0) begin
         step(v.stall);
         chk("stall_reads", 64'(rd_count), 64'((v.len < 9'd4) ? int'(v.len) : 4));
         chk("stall_no_beats", 64'(beats), 64'(0));
         rdy = 1'b1;
      end
      wait_done(1, 200);
      step(3);
      chk("done_count", 64'(done_count), 64'(1));
      chk("first_beat_latency", 64'(first_valid - acc), 64'(3));
      if (v.stall == 0) chk("burst_cycles", 64'(done_cyc - acc), 64'(int'(v.len) + 2));
      chk("done_on_last", 64'(done_last), 64'(1));
      chk("reads_issued", 64'(rd_count), 64'(v.len));
      chk("beats", 64'(beats), 64'(v.len));
      chk("queues_empty", 64'(addr_q.size() + beat_q.size()), 64'(0));
      chk("idle_after", 64'({busy, cmd_ready}), 64'(2'b01));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int acc2;
      int g;
      int rd_before;

      vecs[0] = '{8'h10, 9'd4, 8'd1, 0};
      vecs[1] = '{8'hFE, 9'd3, 8'd3, 0};
      vecs[2] = '{8'h20, 9'd8, 8'd1, 10};
      vecs[3] = '{8'h40, 9'd5, 8'd0, 0};
      vecs[4] = '{8'h80, 9'd1, 8'd7, 0};

      for (int i = 0; i < 256; i++)
         smem[i] = 64'h1234_5678_9ABC_DEF0 ^ (64'(i) * 64'h9E37_79B9_7F4A_7C15);

      step(3);
      rst = 1'b0;
      chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("reset_read_en", 64'(rd_en), 64'(0));
      chk("reset_read_addr", 64'(rd_addr), 64'(0));
      chk("reset_valid", 64'(dvalid), 64'(0));
      chk("reset_data", dout, 64'(0));
      chk("reset_last", 64'(dlast), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      mon_en = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Zero-length command: done the cycle after accept, never busy.
      clear_counts();
      send_cmd(8'h00, 9'd0, 8'd1, acc);
      for (int i = 0; i < 3; i++) begin
         chk("zero_len_ready", 64'(cmd_ready), 64'(1));
         step(1);
      end
      chk("zero_len_done_count", 64'(done_count), 64'(1));
      chk("zero_len_done_cycle", 64'(done_cyc - acc), 64'(1));
      chk("zero_len_reads", 64'(rd_count), 64'(0));

      // Reset in the middle of a long burst.
      clear_counts();
      rdy = 1'b1;
      send_cmd(8'h60, 9'd16, 8'd1, acc);
      g = 0;
      while (beats < 5 && g < 100) begin
         step(1);
         g++;
      end
      chk("pre_reset_beats", 64'(beats), 64'(5));
      mon_en = 1'b0;
      rst    = 1'b1;
      stray  = 1'b1;
      step(1);
      rst = 1'b0;
      addr_q.delete();
      beat_q.delete();
      rd_before = rd_count;
      mon_en = 1'b1;
      chk("mid_rst_read_en", 64'(rd_en), 64'(0));
      chk("mid_rst_valid", 64'(dvalid), 64'(0));
      chk("mid_rst_data", dout, 64'(0));
      chk("mid_rst_last", 64'(dlast), 64'(0));
      chk("mid_rst_done", 64'(done), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
      step(1);
      stray = 1'b0;
      step(4);
      chk("post_rst_no_done", 64'(done_count), 64'(0));
      chk("post_rst_no_beats", 64'(beats), 64'(5));
      chk("post_rst_no_reads", 64'(rd_count), 64'(rd_before));
      run_vec('{8'h70, 9'd2, 8'd5, 0});

      // Second command offered while the first burst is still running.
      clear_counts();
      rdy = 1'b1;
      send_cmd(8'h30, 9'd3, 8'd1, acc);
      send_cmd(8'h50, 9'd2, 8'd2, acc2);
      chk("b2b_first_done_seen", 64'(done_count), 64'(1));
      chk("b2b_accept_after_done", 64'(acc2 - done_cyc), 64'(1));
      wait_done(2, 100);
      step(3);
      chk("b2b_done_count", 64'(done_count), 64'(2));
      chk("b2b_beats", 64'(beats), 64'(5));
      chk("b2b_queues_empty", 64'(addr_q.size() + beat_q.size()), 64'(0));

      chk("fifo_max_occ", 64'(max_occ), 64'(4));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
